// File: rtl/mem_march_bist.sv
// March C- BIST controller: sequences reads/writes into a single-port array,
// stops at the first read mismatch and holds pass/fail results until restarted.
module mem_march_bist #(
    parameter int unsigned          ADDR_BITS = 5,
    parameter int unsigned          DATA_BITS = 8,
    parameter int unsigned          RD_LAT    = 1,
    parameter logic [DATA_BITS-1:0] BG        = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2:0]           fail_elem,
    output logic [ADDR_BITS-1:0] fail_addr,
    output logic [DATA_BITS-1:0] fail_data,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [DATA_BITS-1:0] mem_wdata,
    input  logic [DATA_BITS-1:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

    localparam logic [ADDR_BITS-1:0] AddrMax = '1;
    localparam logic [1:0]           LatLast = 2'(RD_LAT);
    localparam logic [2:0]           ElemLast = 3'd5;

    state_e               state_q, state_d;
    logic [2:0]           elem_q, elem_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [1:0]           lat_q, lat_d;
    logic                 pass_q, pass_d;
    logic [2:0]           fail_elem_q, fail_elem_d;
    logic [ADDR_BITS-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_BITS-1:0] fail_data_q, fail_data_d;

    // Per-element decode of the March C- op list
    logic                 elem_down, next_down, two_ops, last_addr, rd_last, mismatch, do_step;
    logic [DATA_BITS-1:0] exp_data, wr_data;
    logic [2:0]           elem_inc;

    // Element attributes: direction, op count, expected read and write data
    always_comb begin
        elem_inc  = elem_q + 3'd1;
        elem_down = (elem_q == 3'd3) || (elem_q == 3'd4);
        next_down = (elem_inc == 3'd3) || (elem_inc == 3'd4);
        two_ops   = (elem_q != 3'd0) && (elem_q != ElemLast);
        exp_data  = ((elem_q == 3'd2) || (elem_q == 3'd4)) ? ~BG : BG;
        wr_data   = ((elem_q == 3'd1) || (elem_q == 3'd3)) ? ~BG : BG;
        last_addr = elem_down ? (addr_q == '0) : (addr_q == AddrMax);
        rd_last   = (lat_q == LatLast);
        mismatch  = (mem_rdata != exp_data);
    end

    // State register; async reset forces mem_we low immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: address/element walk, read latency counter, results
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            elem_q      <= '0;
            addr_q      <= '0;
            lat_q       <= '0;
            pass_q      <= 1'b0;
            fail_elem_q <= '0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
        end else begin
            elem_q      <= elem_d;
            addr_q      <= addr_d;
            lat_q       <= lat_d;
            pass_q      <= pass_d;
            fail_elem_q <= fail_elem_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
        end
    end

    // Next-state: op sequencing within an address, address walk, element walk
    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        addr_d      = addr_q;
        lat_d       = lat_q;
        pass_d      = pass_q;
        fail_elem_d = fail_elem_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        do_step     = 1'b0;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d     = StWr;
                    elem_d      = '0;
                    addr_d      = '0;
                    lat_d       = '0;
                    pass_d      = 1'b0;
                    fail_elem_d = '0;
                    fail_addr_d = '0;
                    fail_data_d = '0;
                end
            end
            StRd: begin
                if (!rd_last) begin
                    lat_d = lat_q + 2'd1;
                end else begin
                    lat_d = '0;
                    if (mismatch) begin
                        state_d     = StDone;
                        pass_d      = 1'b0;
                        fail_elem_d = elem_q;
                        fail_addr_d = addr_q;
                        fail_data_d = mem_rdata;
                    end else if (two_ops) begin
                        state_d = StWr;
                    end else begin
                        do_step = 1'b1;
                    end
                end
            end
            StWr: do_step = 1'b1;
            default: state_d = StIdle;
        endcase

        // Last op at this address finished: move to next address or element
        if (do_step) begin
            if (last_addr) begin
                if (elem_q == ElemLast) begin
                    state_d = StDone;
                    pass_d  = 1'b1;
                end else begin
                    elem_d  = elem_inc;
                    addr_d  = next_down ? AddrMax : '0;
                    state_d = StRd;
                end
            end else begin
                addr_d  = elem_down ? (addr_q - 1'b1) : (addr_q + 1'b1);
                state_d = (elem_q == 3'd0) ? StWr : StRd;
            end
        end
    end

    // Outputs: array port driven only while in a read or write op
    always_comb begin
        busy      = (state_q == StRd) || (state_q == StWr);
        done      = (state_q == StDone);
        mem_we    = (state_q == StWr);
        mem_addr  = busy ? addr_q : '0;
        mem_wdata = mem_we ? wr_data : '0;
        pass      = pass_q;
        fail_elem = fail_elem_q;
        fail_addr = fail_addr_q;
        fail_data = fail_data_q;
    end

endmodule

// File: tb/tb_mem_march_bist.sv
// Bench for mem_march_bist: one DUT with RD_LAT=1 and one with RD_LAT=0, each
// attached to a behavioural array model with selectable planted faults.
module tb_mem_march_bist;

    typedef struct {
        int         fault;   // 0 none, 1 bit3 SA1 @5, 2 bit0 SA0 @31, 3 write@3 aliases @2
        bit         lat0;    // run on the RD_LAT=0 instance
        bit         poke;    // pulse start mid-run
        bit         pass;
        logic [2:0] elem;
        logic [4:0] addr;
        logic [7:0] data;
        int         cycles;  // expected busy cycles
    } vec_t;

    logic clk = 1'b0;
    logic reset, start_a, start_b, sel_b;
    int   fault;
    int   checks = 0;
    int   failures = 0;
    vec_t vecs[7];
    vec_t exp_q[$];

    logic       busy_a, done_a, pass_a, we_a;
    logic [2:0] fail_elem_a;
    logic [4:0] fail_addr_a, addr_a;
    logic [7:0] fail_data_a, wdata_a, rdata_a;
    logic       busy_b, done_b, pass_b, we_b;
    logic [2:0] fail_elem_b;
    logic [4:0] fail_addr_b, addr_b;
    logic [7:0] fail_data_b, wdata_b, rdata_b;
    logic [7:0] mem_a[32];
    logic [7:0] mem_b[32];

    always #5 clk = ~clk;

    mem_march_bist #(.ADDR_BITS(5), .DATA_BITS(8), .RD_LAT(1), .BG(8'h00)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .fail_elem(fail_elem_a), .fail_addr(fail_addr_a),
        .fail_data(fail_data_a), .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wdata_a),
        .mem_rdata(rdata_a)
    );

    mem_march_bist #(.ADDR_BITS(5), .DATA_BITS(8), .RD_LAT(0), .BG(8'h00)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .fail_elem(fail_elem_b), .fail_addr(fail_addr_b),
        .fail_data(fail_data_b), .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wdata_b),
        .mem_rdata(rdata_b)
    );

    function automatic logic [7:0] rd_fault(input logic [7:0] d, input logic [4:0] a);
        logic [7:0] r;
        r = d;
        if (fault == 1 && a == 5'd5) r = r | 8'h08;
        if (fault == 2 && a == 5'd31) r = r & 8'hFE;
        return r;
    endfunction

    // Array model, 1-cycle read latency
    always @(posedge clk) begin
        if (we_a) begin
            mem_a[addr_a] <= wdata_a;
            if (fault == 3 && addr_a == 5'd3) mem_a[2] <= wdata_a;
        end
        rdata_a <= rd_fault(mem_a[addr_a], addr_a);
    end

    // Array model, combinational read
    always @(posedge clk) begin
        if (we_b) begin
            mem_b[addr_b] <= wdata_b;
            if (fault == 3 && addr_b == 5'd3) mem_b[2] <= wdata_b;
        end
    end
    assign rdata_b = rd_fault(mem_b[addr_b], addr_b);

    logic       o_busy, o_done, o_pass, o_we;
    logic [2:0] o_elem;
    logic [4:0] o_addr, o_maddr;
    logic [7:0] o_data, o_wdata;
    assign o_busy  = sel_b ? busy_b : busy_a;
    assign o_done  = sel_b ? done_b : done_a;
    assign o_pass  = sel_b ? pass_b : pass_a;
    assign o_we    = sel_b ? we_b : we_a;
    assign o_elem  = sel_b ? fail_elem_b : fail_elem_a;
    assign o_addr  = sel_b ? fail_addr_b : fail_addr_a;
    assign o_data  = sel_b ? fail_data_b : fail_data_a;
    assign o_maddr = sel_b ? addr_b : addr_a;
    assign o_wdata = sel_b ? wdata_b : wdata_a;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_start(input bit lat0, input logic v);
        if (lat0) start_b = v;
        else start_a = v;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 32'(o_busy), 0);
        check({tag, "_done"}, 32'(o_done), 0);
        check({tag, "_pass"}, 32'(o_pass), 0);
        check({tag, "_we"}, 32'(o_we), 0);
        check({tag, "_maddr"}, 32'(o_maddr), 0);
        check({tag, "_wdata"}, 32'(o_wdata), 0);
        check({tag, "_felem"}, 32'(o_elem), 0);
        check({tag, "_faddr"}, 32'(o_addr), 0);
        check({tag, "_fdata"}, 32'(o_data), 0);
    endtask

    // Start one run, push its expected result, wait for done and compare
    task automatic run_one(input int idx);
        vec_t v;
        vec_t e;
        int   cnt;
        bit   got;
        v = vecs[idx];
        fault = v.fault;
        sel_b = v.lat0;
        @(negedge clk);
        drive_start(v.lat0, 1'b1);
        exp_q.push_back(v);
        @(negedge clk);
        drive_start(v.lat0, 1'b0);
        cnt = 0;
        got = 0;
        for (int c = 0; c < 2000 && !got; c++) begin
            if (o_done) begin
                got = 1;
            end else begin
                if (o_busy) cnt++;
                drive_start(v.lat0, (v.poke && cnt == 50) ? 1'b1 : 1'b0);
                @(negedge clk);
            end
        end
        drive_start(v.lat0, 1'b0);
        check($sformatf("v%0d_done", idx), 32'(got), 1);
        e = exp_q.pop_front();
        check($sformatf("v%0d_cycles", idx), 32'(cnt), 32'(e.cycles));
        check($sformatf("v%0d_pass", idx), 32'(o_pass), 32'(e.pass));
        check($sformatf("v%0d_elem", idx), 32'(o_elem), 32'(e.elem));
        check($sformatf("v%0d_addr", idx), 32'(o_addr), 32'(e.addr));
        check($sformatf("v%0d_data", idx), 32'(o_data), 32'(e.data));
        check($sformatf("v%0d_we_done", idx), 32'(o_we), 0);
        check($sformatf("v%0d_maddr_done", idx), 32'(o_maddr), 0);
        // Results must hold in DONE
        repeat (3) @(negedge clk);
        check($sformatf("v%0d_hold_done", idx), 32'(o_done), 1);
        check($sformatf("v%0d_hold_pass", idx), 32'(o_pass), 32'(e.pass));
    endtask

    initial begin
        int  cnt;
        bit  hit;
        // Failing-run cycle counts: M0 is N cycles, each two-op address costs
        // RD_LAT+2, and the failing read costs RD_LAT+1.
        vecs[0] = '{0, 1'b0, 1'b0, 1'b1, 3'd0, 5'd0,  8'h00, 480};
        vecs[1] = '{1, 1'b0, 1'b0, 1'b0, 3'd1, 5'd5,  8'h08, 49};
        vecs[2] = '{2, 1'b0, 1'b0, 1'b0, 3'd2, 5'd31, 8'hFE, 223};
        // The alias is overwritten by the ascending M1/M2 writes at addr 2; it
        // first shows when descending M3 writes addr 3 before reading addr 2.
        vecs[3] = '{3, 1'b0, 1'b0, 1'b0, 3'd3, 5'd2,  8'hFF, 313};
        vecs[4] = '{0, 1'b0, 1'b1, 1'b1, 3'd0, 5'd0,  8'h00, 480};
        vecs[5] = '{0, 1'b1, 1'b0, 1'b1, 3'd0, 5'd0,  8'h00, 320};
        vecs[6] = '{1, 1'b1, 1'b0, 1'b0, 3'd1, 5'd5,  8'h08, 43};

        reset = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        sel_b = 1'b0;
        fault = 0;
        repeat (3) @(negedge clk);
        check_idle_outputs("rst_a");
        sel_b = 1'b1;
        #1;
        check_idle_outputs("rst_b");
        reset = 1'b0;

        for (int i = 0; i < 7; i++) run_one(i);

        // Reset mid-run during a write cycle
        fault = 0;
        sel_b = 1'b0;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        cnt = 0;
        hit = 0;
        for (int c = 0; c < 400 && !hit; c++) begin
            if (busy_a) cnt++;
            if (cnt >= 100 && we_a) hit = 1;
            else @(negedge clk);
        end
        check("midrst_reached", 32'(hit), 1);
        check("midrst_we_before", 32'(we_a), 1);
        reset = 1'b1;
        #1;
        check_idle_outputs("midrst");
        @(negedge clk);
        reset = 1'b0;
        run_one(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
